mips_dmem_arbiter: RTL

//  Two-port arbiter/sequencer sharing the single-port MIPS data memory between port A (CPU load/store

---
 rtl/mips_dmem_arbiter_if.sv | 60 ++++++
 rtl/mips_dmem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mips_dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and mips_dmem_arbiter.
// Error outputs exist only when MIPS_DMEM_ARB_BOUNDS_EN is defined.
interface mips_dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_store_data;
    logic              mem_write_signal;
    logic [DATA_W-1:0] mem_load_data;
    logic              busy;
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
    logic              a_err;
    logic              b_err;
`endif

    // Requesters plus memory model side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_done, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_done, b_rdata,
        input  mem_addr, mem_store_data, mem_write_signal,
        output mem_load_data,
        input  busy
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
        , input a_err, b_err
`endif
    );

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_done, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_done, b_rdata,
        output mem_addr, mem_store_data, mem_write_signal,
        input  mem_load_data,
        output busy
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
        , output a_err, b_err
`endif
    );
endinterface

// File: rtl/mips_dmem_arbiter.sv
// Two-port arbiter sharing a single-port MIPS data memory; one access per IDLE->ACCESS->DONE pass.
// Optional address bounds check enabled by defining MIPS_DMEM_ARB_BOUNDS_EN.
module mips_dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    if (DEPTH == 0) begin : g_depth_chk
        $error("mips_dmem_arbiter: DEPTH must be nonzero");
    end

    state_t            state;
    logic              op_port;      // 0 = A, 1 = B
    logic              op_we;
    logic              last_winner;  // 0 = A, 1 = B
    logic              wr_q;
    logic              a_done_q, b_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    logic              tie_to_b, pick_b, grant;
    logic              sel_we, addr_ok, cap_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, cap_data;

    // Winner select: B wins alone, or on a tie when round-robin says A went last
    assign tie_to_b  = (FIXED_PRI == 0) && !last_winner;
    assign pick_b    = bus.b_req && (!bus.a_req || tie_to_b);
    assign grant     = reset_n && (state == ST_IDLE) && (bus.a_req || bus.b_req);
    assign sel_we    = pick_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;

`ifdef MIPS_DMEM_ARB_BOUNDS_EN
    logic op_ok;
    logic a_err_q, b_err_q;
    assign addr_ok  = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    assign cap_en   = !op_we || !op_ok;
    assign cap_data = op_ok ? bus.mem_load_data : '0;
    assign bus.a_err = a_err_q;
    assign bus.b_err = b_err_q;
`else
    assign addr_ok  = 1'b1;
    assign cap_en   = !op_we;
    assign cap_data = bus.mem_load_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            op_port     <= 1'b0;
            op_we       <= 1'b0;
            last_winner <= 1'b1;
            wr_q        <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
            op_ok       <= 1'b0;
            a_err_q     <= 1'b0;
            b_err_q     <= 1'b0;
`endif
        end else begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
            a_err_q  <= 1'b0;
            b_err_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        op_port <= pick_b;
                        op_we   <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wr_q    <= sel_we && addr_ok;
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
                        op_ok   <= addr_ok;
`endif
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wr_q <= 1'b0;
                    if (cap_en) begin
                        if (op_port) b_rdata_q <= cap_data;
                        else         a_rdata_q <= cap_data;
                    end
                    a_done_q <= !op_port;
                    b_done_q <= op_port;
`ifdef MIPS_DMEM_ARB_BOUNDS_EN
                    a_err_q  <= !op_port && !op_ok;
                    b_err_q  <= op_port && !op_ok;
`endif
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    last_winner <= op_port;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a_gnt            = grant && !pick_b;
    assign bus.b_gnt            = grant && pick_b;
    assign bus.a_done           = a_done_q;
    assign bus.b_done           = b_done_q;
    assign bus.a_rdata          = a_rdata_q;
    assign bus.b_rdata          = b_rdata_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_store_data   = wdata_q;
    // Gated by reset so a write pending in ACCESS is dropped on the reset edge
    assign bus.mem_write_signal = wr_q && reset_n;
    assign bus.busy             = (state != ST_IDLE);
endmodule
